// File: rtl/rx_ctrl_uart.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling off a baud divider, byte + one-cycle strobe out.
// Optional build macro RX_CTRL_UART_MAJ3_EN selects 2-of-3 majority sampling over the last three rx_s values.
module rx_ctrl_uart #(
    parameter int BAUD_DIV = 434,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_ferr,
    output logic       rx_busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;

    localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic        sync1_q;
    logic        rx_s_q;
    logic [1:0]  settle_q,  settle_d;
    logic        prev_q,    prev_d;
    logic [2:0]  state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [2:0]  bit_q,     bit_d;
    logic [7:0]  shift_q,   shift_d;
    logic [7:0]  data_q,    data_d;
    logic        vld_q,     vld_d;
    logic        ferr_q,    ferr_d;

    logic        settled;
    logic        fall;
    logic        at_sample;
    logic        sample;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            rx_s_q  <= sync1_q;
        end
    end

`ifdef RX_CTRL_UART_MAJ3_EN
    // hist_q[0] is rx_s one cycle back, hist_q[1] two cycles back.
    logic [1:0] hist_q;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign sample = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rx_s_q;
`endif

    // The synchronizer resets high, so edges are only trusted once it has
    // flushed real line values; a line held low through reset never starts a frame.
    assign settled = (settle_q == 2'd2);
    assign fall    = settled & prev_q & ~rx_s_q;

    always_comb begin
        at_sample = 1'b0;
        unique case (state_q)
            S_START:       at_sample = (cnt_q == HALF_LAST);
            S_DATA, S_STOP: at_sample = (cnt_q == BAUD_LAST);
            default:       at_sample = 1'b0;
        endcase
    end

    always_comb begin
        settle_d = settled ? settle_q : settle_q + 2'd1;
        prev_d   = settled ? rx_s_q : 1'b0;
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (at_sample) begin
                    if (sample) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (at_sample) begin
                    shift_d = {sample, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (at_sample) begin
                    if (sample) begin
                        data_d  = shift_q;
                        vld_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter restarts on every state entry and at every sample point.
        if ((state_d != state_q) || at_sample) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            settle_q <= 2'd0;
            prev_q   <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            data_q   <= 8'h00;
            vld_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            settle_q <= settle_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            ferr_q   <= ferr_d;
        end
    end

    assign rx_data = data_q;
    assign rx_vld  = vld_q;
    assign rx_ferr = ferr_q;
    assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_ctrl_uart.sv
// Scoreboard bench for rx_ctrl_uart: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_rx_ctrl_uart;

    localparam int B    = 16;
    localparam int HALF = B / 2;

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_ferr;
    logic       rx_busy;

    rx_ctrl_uart #(.BAUD_DIV(B)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         t_start = 0;
    int         last_vld_cyc = 0;
    logic [7:0] hold_data = 8'h00;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reset state while rst is high, otherwise every strobe must match the queue head.
    always @(negedge clk_sys) begin
        exp_t e;
        if (rst) begin
            check("reset_outputs", {rx_data, rx_vld, rx_ferr, rx_busy}, 32'h0);
            hold_data = 8'h00;
        end else begin
            if (rx_vld && rx_ferr) check("vld_ferr_overlap", 32'd1, 32'd0);
            if (rx_vld || rx_ferr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {rx_vld, rx_ferr, rx_data}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", {31'd0, rx_ferr}, {31'd0, e.is_ferr});
                    if (!e.is_ferr) begin
                        check("rx_data", rx_data, e.data);
                        check("busy_after_vld", rx_busy, 1'b0);
                        hold_data = e.data;
                        last_vld_cyc = cyc;
                    end else begin
                        check("data_hold_on_ferr", rx_data, hold_data);
                    end
                end
            end else if (rx_data !== hold_data) begin
                check("rx_data_hold", rx_data, hold_data);
            end
        end
    end

    task automatic expect_vld(input logic [7:0] d);
        exp_t e;
        e.is_ferr = 1'b0;
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ferr();
        exp_t e;
        e.is_ferr = 1'b1;
        e.data    = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic drive_cycles(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1 uart_rx = v;
        end
    endtask

    // One 8N1 frame; optional glitch at each data mid-bit, optional reset inside bit index rst_bit.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit glitch, input int rst_bit);
        logic [9:0] bits;
        logic       v;
        bits = {stop, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < B; c++) begin
                @(posedge clk_sys);
                #1;
                v = bits[b];
                if (glitch && b >= 1 && b <= 8 && c == HALF) v = ~v;
                uart_rx = v;
                if (b == 0 && c == 0) t_start = cyc;
                if (b == rst_bit && c == 3) rst = 1'b1;
                if (b == rst_bit && c == 5) rst = 1'b0;
            end
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 40 * B) begin
            @(posedge clk_sys);
            i++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] byte_list [4];
        byte_list[0] = 8'h00;
        byte_list[1] = 8'hFF;
        byte_list[2] = 8'h55;
        byte_list[3] = 8'h01;

        drive_cycles(1'b1, 3);
        rst = 1'b0;
        drive_cycles(1'b1, 2 * B);

        // 1: single byte, also checks start-edge to strobe latency
        expect_vld(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        drain("t1_drain");
        check("t1_latency", last_vld_cyc - t_start, 3 + HALF + 9 * B);
        drive_cycles(1'b1, B);

        // 2: back-to-back frames with zero idle
        for (int i = 0; i < 4; i++) expect_vld(byte_list[i]);
        for (int i = 0; i < 4; i++) send_frame(byte_list[i], 1'b1, 1'b0, -1);
        drain("t2_drain");
        drive_cycles(1'b1, B);

        // 3: short low glitch is rejected as a false start
        drive_cycles(1'b0, 4);
        drive_cycles(1'b1, 3 * B);
        check("t3_idle_after_glitch", rx_busy, 1'b0);
        expect_vld(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        drain("t3_drain");
        drive_cycles(1'b1, B);

        // 4: framing error followed by a long break
        expect_ferr();
        send_frame(8'h81, 1'b0, 1'b0, -1);
        drive_cycles(1'b0, 40 * B);
        drain("t4_ferr_drain");
        drive_cycles(1'b1, 2 * B);
        check("t4_idle_after_break", rx_busy, 1'b0);
        expect_vld(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        drain("t4_drain");
        drive_cycles(1'b1, B);

        // 5: reset during data bit 4 discards the frame
        send_frame(8'hC3, 1'b1, 1'b0, 5);
        drive_cycles(1'b1, 2 * B);
        check("t5_idle_after_reset", rx_busy, 1'b0);
        expect_vld(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        drain("t5_drain");
        drive_cycles(1'b1, B);

        // 6: single-cycle inverted glitch at every data sample point
`ifdef RX_CTRL_UART_MAJ3_EN
        expect_vld(8'h96);
`else
        expect_vld(~8'h96);
`endif
        send_frame(8'h96, 1'b1, 1'b1, -1);
        drain("t6_drain");
        drive_cycles(1'b1, B);

        // Randomized frames with random idle gaps
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            expect_vld(rb);
            send_frame(rb, 1'b1, 1'b0, -1);
            drive_cycles(1'b1, $urandom_range(0, 20));
        end
        drain("rand_drain");
        drive_cycles(1'b1, 2 * B);
        check("final_busy", rx_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
